// File: rtl/rgb_conv_pkg.sv
// rgb_conv_pkg: shared widths and types for the streaming RGB convolver.
// Holds product/accumulator width helpers and the rounding-mode enum.
package rgb_conv_pkg;

  typedef enum logic {
    RND_TRUNC,
    RND_HALF_UP
  } round_mode_e;

  function automatic int prod_w(
    input int coef_w,
    input int pix_w
  );
    return coef_w + pix_w + 1;
  endfunction

  function automatic int acc_w(
    input int pw,
    input int ksize
  );
    return pw + $clog2(ksize * ksize);
  endfunction

endpackage

// File: rtl/conv_channel_mac.sv
// conv_channel_mac: one channel's S1 products and S2 adder tree.
// Ports: clk_i/rst_ni, ld1_i/ld2_i stage loads, pix_i/coef_i window, acc_o sum.
module conv_channel_mac
  import rgb_conv_pkg::*;
#(
  parameter int KSIZE  = 3,
  parameter int PIX_W  = 8,
  parameter int COEF_W = 12
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ld1_i,
  input  logic ld2_i,
  input  logic [KSIZE*KSIZE*PIX_W-1:0]  pix_i,
  input  logic [KSIZE*KSIZE*COEF_W-1:0] coef_i,
  output logic signed [acc_w(prod_w(COEF_W, PIX_W), KSIZE)-1:0] acc_o
);

  localparam int N      = KSIZE * KSIZE;
  localparam int PROD_W = prod_w(COEF_W, PIX_W);
  localparam int ACC_W  = acc_w(PROD_W, KSIZE);
  localparam int LV     = $clog2(N);
  localparam int P      = 1 << LV;

  logic signed [PROD_W-1:0] ca [N];
  logic signed [PROD_W-1:0] pa [N];
  logic signed [PROD_W-1:0] prod_d [N];
  logic signed [PROD_W-1:0] prod_q [N];
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  acc_q;

  // Heap-indexed balanced tree: leaves at P..2P-1, node i sums 2i and 2i+1.
  function automatic logic signed [ACC_W-1:0] tree_f(
    input logic signed [PROD_W-1:0] p [N]
  );
    logic signed [ACC_W-1:0] t [2*P];
    for (int i = 0; i < 2 * P; i++) t[i] = '0;
    for (int i = 0; i < N; i++) t[P+i] = ACC_W'(p[i]);
    for (int i = P - 1; i >= 1; i--) t[i] = t[2*i] + t[2*i+1];
    return t[1];
  endfunction

  // Pixels are zero-extended so the multiply stays signed.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      ca[k] = PROD_W'($signed(coef_i[k*COEF_W +: COEF_W]));
      pa[k] = PROD_W'($signed({1'b0, pix_i[k*PIX_W +: PIX_W]}));
      prod_d[k] = ca[k] * pa[k];
    end
  end

  assign acc_d = tree_f(prod_q);
  assign acc_o = acc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_q <= '{default: '0};
      acc_q  <= '0;
    end else begin
      if (ld1_i) prod_q <= prod_d;
      if (ld2_i) acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/rgb_conv_stream.sv
// rgb_conv_stream: 3-stage valid/ready NUM_CH-channel KSIZE^2 convolver.
// Ports: valid_i/ready_o, pix_i, coef_i, round_i in; valid_o/ready_i, pix_o, clip_o out.
module rgb_conv_stream
  import rgb_conv_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int KSIZE  = 3,
  parameter int PIX_W  = 8,
  parameter int COEF_W = 12,
  parameter int FRAC_W = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  output logic ready_o,
  input  logic [NUM_CH*KSIZE*KSIZE*PIX_W-1:0] pix_i,
  input  logic [KSIZE*KSIZE*COEF_W-1:0]       coef_i,
  input  logic round_i,
  output logic valid_o,
  input  logic ready_i,
  output logic [NUM_CH*PIX_W-1:0] pix_o,
  output logic [NUM_CH-1:0]       clip_o
);

  localparam int N      = KSIZE * KSIZE;
  localparam int WIN_W  = N * PIX_W;
  localparam int PROD_W = prod_w(COEF_W, PIX_W);
  localparam int ACC_W  = acc_w(PROD_W, KSIZE);
  localparam int TW     = ACC_W + 1;
  localparam logic signed [TW-1:0] MAXV  = TW'((1 << PIX_W) - 1);
  localparam logic signed [TW-1:0] RHALF = TW'(1 << (FRAC_W - 1));

  logic v1_q, v2_q, v3_q;
  logic ld1, ld2, ld3;
  logic en1, en2, en3;
  round_mode_e rnd1_q, rnd2_q;
  logic signed [ACC_W-1:0] acc [NUM_CH];
  logic [NUM_CH*PIX_W-1:0] pix_d, pix_q;
  logic [NUM_CH-1:0] clip_d, clip_q;

  // A stage loads when empty or when the stage after it moves.
  assign ld3 = !v3_q | ready_i;
  assign ld2 = !v2_q | ld3;
  assign ld1 = !v1_q | ld2;
  assign ready_o = ld1;

  // Data registers only move with a real beat behind them.
  assign en1 = ld1 & valid_i;
  assign en2 = ld2 & v1_q;
  assign en3 = ld3 & v2_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    conv_channel_mac #(
      .KSIZE (KSIZE),
      .PIX_W (PIX_W),
      .COEF_W(COEF_W)
    ) u_mac (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .ld1_i (en1),
      .ld2_i (en2),
      .pix_i (pix_i[c*WIN_W +: WIN_W]),
      .coef_i(coef_i),
      .acc_o (acc[c])
    );
  end

  // Returns {clip, pixel}. Sign-extend one bit so the rounding add can't wrap.
  function automatic logic [PIX_W:0] sat_f(
    input logic signed [ACC_W-1:0] a,
    input round_mode_e rnd
  );
    logic signed [TW-1:0] t;
    logic signed [TW-1:0] r;
    t = TW'(a);
    if (rnd == RND_HALF_UP) t = t + RHALF;
    r = t >>> FRAC_W;
    unique case (1'b1)
      r[TW-1]:  return {1'b1, {PIX_W{1'b0}}};
      r > MAXV: return {1'b1, {PIX_W{1'b1}}};
      default:  return {1'b0, r[PIX_W-1:0]};
    endcase
  endfunction

  always_comb begin
    pix_d  = '0;
    clip_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      {clip_d[c], pix_d[c*PIX_W +: PIX_W]} = sat_f(acc[c], rnd2_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      rnd1_q <= RND_TRUNC;
      rnd2_q <= RND_TRUNC;
      pix_q  <= '0;
      clip_q <= '0;
    end else begin
      if (ld1) v1_q <= valid_i;
      if (ld2) v2_q <= v1_q;
      if (ld3) v3_q <= v2_q;
      if (en1) rnd1_q <= round_mode_e'(round_i);
      if (en2) rnd2_q <= rnd1_q;
      if (en3) begin
        pix_q  <= pix_d;
        clip_q <= clip_d;
      end
    end
  end

  assign valid_o = v3_q;
  assign pix_o   = pix_q;
  assign clip_o  = clip_q;

endmodule

// File: tb/tb_rgb_conv_stream.sv
// tb_rgb_conv_stream: scoreboard bench for rgb_conv_stream.
// Real-arithmetic reference model, random and directed beats.
module tb_rgb_conv_stream;

  localparam int NC = 3;
  localparam int K  = 3;
  localparam int N  = K * K;
  localparam int PW = 8;
  localparam int CW = 12;
  localparam int FW = 4;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic valid_i = 1'b0;
  logic ready_o;
  logic [NC*N*PW-1:0] pix_i = '0;
  logic [N*CW-1:0] coef_i = '0;
  logic round_i = 1'b0;
  logic valid_o;
  logic ready_i = 1'b0;
  logic [NC*PW-1:0] pix_o;
  logic [NC-1:0] clip_o;

  always #5 clk = ~clk;

  rgb_conv_stream #(
    .NUM_CH(NC), .KSIZE(K), .PIX_W(PW),
    .COEF_W(CW), .FRAC_W(FW)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .pix_i  (pix_i),
    .coef_i (coef_i),
    .round_i(round_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .pix_o  (pix_o),
    .clip_o (clip_o)
  );

  typedef struct {
    logic [NC*PW-1:0] pix;
    logic [NC-1:0]    clip;
    int               cyc;
    bit               lat;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pix_a [NC][N];
  int coef_a [N];
  bit hold = 0;
  logic [NC*PW-1:0] hp;
  logic [NC-1:0] hc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Model: exact sum, scale by 2^-FW, floor (after +0.5 if rounding), clamp.
  task automatic push(input bit rnd, input bit lat);
    exp_t e;
    longint s, r;
    real x;
    e.pix = '0;
    e.clip = '0;
    for (int c = 0; c < NC; c++) begin
      s = 0;
      for (int k = 0; k < N; k++)
        s += longint'(coef_a[k]) * longint'(pix_a[c][k]);
      x = real'(s) / real'(1 << FW);
      if (rnd) x = x + 0.5;
      r = longint'($floor(x));
      if (r < 0) begin
        e.pix[c*PW +: PW] = '0;
        e.clip[c] = 1'b1;
      end else if (r > (1 << PW) - 1) begin
        e.pix[c*PW +: PW] = '1;
        e.clip[c] = 1'b1;
      end else begin
        e.pix[c*PW +: PW] = PW'(r);
      end
    end
    e.cyc = cyc;
    e.lat = lat;
    q.push_back(e);
  endtask

  task automatic drive_data();
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < N; k++)
        pix_i[(c*N+k)*PW +: PW] = PW'(pix_a[c][k]);
    for (int k = 0; k < N; k++)
      coef_i[k*CW +: CW] = CW'(coef_a[k]);
  endtask

  task automatic rand_beat();
    logic signed [CW-1:0] cs;
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < N; k++)
        pix_a[c][k] = int'($urandom_range(0, 255));
    for (int k = 0; k < N; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        cs = CW'($urandom);
        coef_a[k] = int'(cs);
      end else begin
        coef_a[k] = int'($urandom_range(0, 64)) - 32;
      end
    end
  endtask

  task automatic set_coef(input int all, input int ctr);
    for (int k = 0; k < N; k++) coef_a[k] = all;
    coef_a[N/2] = ctr;
  endtask

  task automatic set_pix(input int all);
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < N; k++) pix_a[c][k] = all;
  endtask

  // One cycle: drive, sample ready_o at negedge, record accepted beats.
  task automatic step(input bit v, input bit rdy, input bit rnd,
                      input bit lat, output bit acc, output bit ro);
    valid_i = v;
    ready_i = rdy;
    round_i = rnd;
    drive_data();
    @(negedge clk);
    ro = ready_o;
    if (rdy) chk("ready_o_when_sink_ready", ready_o, 1);
    acc = v && ready_o;
    if (acc) push(rnd, lat);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_queue_empty", q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_ni) begin
      if (hold) begin
        total++;
        if (!valid_o || pix_o !== hp || clip_o !== hc) begin
          bad++;
          $display("FAIL stall_hold: got v=%0b pix=%h clip=%b want v=1 pix=%h clip=%b",
                   valid_o, pix_o, clip_o, hp, hc);
        end
      end
      if (valid_o && ready_i) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL spurious_beat: got pix=%h want none", pix_o);
        end else begin
          me = q.pop_front();
          if (pix_o !== me.pix || clip_o !== me.clip) begin
            bad++;
            $display("FAIL out_data: got pix=%h clip=%b want pix=%h clip=%b",
                     pix_o, clip_o, me.pix, me.clip);
          end
          if (me.lat) begin
            total++;
            if (cyc - me.cyc != 3) begin
              bad++;
              $display("FAIL latency: got %0d want 3", cyc - me.cyc);
            end
          end
        end
      end
      hold = valid_o && !ready_i;
      hp = pix_o;
      hc = clip_o;
    end else begin
      hold = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc, ro;
    int bi;
    set_coef(0, 0);
    set_pix(0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid_o", valid_o, 0);
    chk("reset_pix_o", pix_o, 0);
    chk("reset_clip_o", clip_o, 0);
    chk("reset_ready_o", ready_o, 1);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // Identity
    rand_beat();
    set_coef(0, 16);
    pix_a[0][N/2] = 100;
    pix_a[1][N/2] = 7;
    pix_a[2][N/2] = 255;
    step(1, 1, 0, 1, acc, ro);
    drain();

    // Saturation low then high
    set_coef(-16, -16);
    set_pix(200);
    step(1, 1, 0, 0, acc, ro);
    set_coef(16, 16);
    set_pix(255);
    step(1, 1, 0, 0, acc, ro);
    drain();

    // Rounding, alternating per beat; then a negative tie
    set_coef(0, 24);
    set_pix(3);
    for (int i = 0; i < 4; i++) step(1, 1, i[0], 0, acc, ro);
    set_coef(0, -40);
    set_pix(1);
    step(1, 1, 1, 0, acc, ro);
    step(1, 1, 0, 0, acc, ro);
    drain();

    // Backpressure: 8 distinct beats, sink stalled for cycles 2..7
    bi = 0;
    for (int t = 0; t < 40 && bi < 8; t++) begin
      rand_beat();
      set_coef(0, 16);
      for (int c = 0; c < NC; c++) pix_a[c][N/2] = 10 * bi + 5 + c;
      if (t >= 2 && t <= 7) begin
        step(1, 0, 0, 0, acc, ro);
        chk("ready_o_backpressure", ro, (bi < 3) ? 1 : 0);
      end else begin
        step(1, 1, 0, 0, acc, ro);
      end
      if (acc) bi++;
    end
    chk("bp_all_accepted", bi, 8);
    drain();

    // Bubbles: valid and ready out of phase
    for (int t = 0; t < 16; t++) begin
      rand_beat();
      step(t % 2 == 0, t % 2 == 1, 1'($urandom), 0, acc, ro);
    end
    drain();

    // Random traffic
    for (int t = 0; t < 400; t++) begin
      rand_beat();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           1'($urandom), 0, acc, ro);
    end
    drain();

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      rand_beat();
      step(1, 0, 0, 0, acc, ro);
    end
    chk("full_ready_o", ready_o, 0);
    @(negedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("midrst_valid_o", valid_o, 0);
    chk("midrst_pix_o", pix_o, 0);
    q.delete();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    #1;
    chk("post_rst_ready_o", ready_o, 1);
    rand_beat();
    step(1, 1, 1, 1, acc, ro);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
